// File: rtl/if_stage_qbuf.sv
// if_stage_qbuf: instruction-fetch stage with a DEPTH-entry in-order fetch queue.
//
// Each request issued by pre-IF gets a queue entry. SRAM responses are matched
// to entries in issue order. On an exception or eret the queue is cleared, and
// responses still owed for the discarded entries are counted in cancel_cnt so
// they can be dropped when they arrive.
//
// Optional feature: define IF_DATA_BYPASS_EN to forward a response for the
// head entry to ID in the same cycle it arrives.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pfs_to_fs_valid/_bus       pre-IF entry {adef, pc}
//   fs_allowin                 an entry may be pushed this cycle
//   fs_buff_full               queue occupancy == DEPTH
//   ds_allowin                 ID accepts the presented entry
//   fs_to_ds_valid/_bus        head entry {ex, bd, badvaddr, inst, pc} to ID
//   ds_is_branch               copied combinationally to bd
//   inst_sram_rdata/_data_ok   one in-order SRAM response
//   inst_sram_data_waiting     a response is still owed (queued or cancelled)
//   ws_ex, ws_eret             flush requests
module if_stage_qbuf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pfs_to_fs_valid,
  input  logic [32:0] pfs_to_fs_bus,
  output logic        fs_allowin,
  output logic        fs_buff_full,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [97:0] fs_to_ds_bus,
  input  logic        ds_is_branch,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_data_ok,
  output logic        inst_sram_data_waiting,
  input  logic        ws_ex,
  input  logic        ws_eret
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ok_q, ok_d;
  logic [DEPTH-1:0] ex_q, ex_d;
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      pc_d [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d, cancel_q, cancel_d;

  logic            flush, push, pop, fill_hit, byp_hit, match_found;
  logic [PtrW-1:0] match_idx, idx;
  logic [CntW-1:0] pending_cnt, drain_cnt;
  logic [CntW:0]   occ_sum;
  logic [31:0]     head_inst;

  assign flush = ws_ex | ws_eret;

  // Entries still waiting for their SRAM response.
  always_comb begin
    pending_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !ok_q[i]) pending_cnt = pending_cnt + CntW'(1);
    end
  end

  // Oldest pending entry, searching from head; adef entries are already ok.
  always_comb begin
    match_found = 1'b0;
    match_idx   = head_q;
    idx         = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (!match_found && valid_q[idx] && !ok_q[idx]) begin
        match_found = 1'b1;
        match_idx   = idx;
      end
    end
  end

  assign fill_hit = inst_sram_data_ok && (cancel_q == '0) && match_found && !flush;

`ifdef IF_DATA_BYPASS_EN
  assign byp_hit = fill_hit && (match_idx == head_q);
`else
  assign byp_hit = 1'b0;
`endif

  // Cancelled responses still reserve a slot, so they bound cancel_cnt to DEPTH.
  assign occ_sum      = (CntW + 1)'(count_q) + (CntW + 1)'(cancel_q);
  assign fs_allowin   = occ_sum < (CntW + 1)'(DEPTH);
  assign fs_buff_full = count_q == CntW'(DEPTH);

  assign fs_to_ds_valid = valid_q[head_q] && (ok_q[head_q] || byp_hit) && !flush;
  assign head_inst      = byp_hit ? inst_sram_rdata : inst_q[head_q];
  assign fs_to_ds_bus   = {ex_q[head_q], ds_is_branch, pc_q[head_q], head_inst, pc_q[head_q]};

  assign push = pfs_to_fs_valid && fs_allowin && !flush;
  assign pop  = fs_to_ds_valid && ds_allowin;

  assign inst_sram_data_waiting = (cancel_q != '0) || (pending_cnt != '0);

  // A data_ok in the flush cycle belongs to the old stream, so it is taken off
  // the owed total whether it would have been dropped or filled.
  assign drain_cnt = cancel_q + pending_cnt;

  always_comb begin
    valid_d  = valid_q;
    ok_d     = ok_q;
    ex_d     = ex_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cancel_d = cancel_q;
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (inst_sram_data_ok && (drain_cnt != '0)) cancel_d = drain_cnt - CntW'(1);
      else                                         cancel_d = drain_cnt;
    end else begin
      // A bypassed response that pops immediately is never stored.
      if (fill_hit && !(byp_hit && pop)) begin
        ok_d[match_idx]   = 1'b1;
        inst_d[match_idx] = inst_sram_rdata;
      end
      if (inst_sram_data_ok && (cancel_q != '0)) cancel_d = cancel_q - CntW'(1);
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PtrW'(1);
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        ex_d[tail_q]    = pfs_to_fs_bus[32];
        ok_d[tail_q]    = pfs_to_fs_bus[32];
        pc_d[tail_q]    = pfs_to_fs_bus[31:0];
        inst_d[tail_q]  = '0;
        tail_d          = tail_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      ok_q     <= '0;
      ex_q     <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cancel_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      ok_q     <= ok_d;
      ex_q     <= ex_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cancel_q <= cancel_d;
    end
  end

endmodule

// File: tb/tb_if_stage_qbuf.sv
// Self-checking bench for if_stage_qbuf (DEPTH=4). Expected ID transfers are
// queued when pre-IF entries are offered and compared as ID accepts them.
module tb_if_stage_qbuf;

`ifdef IF_DATA_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pfs_to_fs_valid;
  logic [32:0] pfs_to_fs_bus;
  logic        fs_allowin;
  logic        fs_buff_full;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [97:0] fs_to_ds_bus;
  logic        ds_is_branch;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_data_ok;
  logic        inst_sram_data_waiting;
  logic        ws_ex;
  logic        ws_eret;

  if_stage_qbuf #(.DEPTH(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .pfs_to_fs_valid        (pfs_to_fs_valid),
    .pfs_to_fs_bus          (pfs_to_fs_bus),
    .fs_allowin             (fs_allowin),
    .fs_buff_full           (fs_buff_full),
    .ds_allowin             (ds_allowin),
    .fs_to_ds_valid         (fs_to_ds_valid),
    .fs_to_ds_bus           (fs_to_ds_bus),
    .ds_is_branch           (ds_is_branch),
    .inst_sram_rdata        (inst_sram_rdata),
    .inst_sram_data_ok      (inst_sram_data_ok),
    .inst_sram_data_waiting (inst_sram_data_waiting),
    .ws_ex                  (ws_ex),
    .ws_eret                (ws_eret)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [97:0] exp_q[$];
  logic [97:0] mon_exp;

  task automatic check(input string tag, input logic [97:0] got, input logic [97:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [97:0] mk(input bit ex, input logic [31:0] pc,
                                     input logic [31:0] inst);
    return {ex, 1'b0, pc, inst, pc};
  endfunction

  // Scoreboard: every ID handshake must match the oldest expected transfer.
  always @(negedge clk) begin
    if (!reset && fs_to_ds_valid && ds_allowin) begin
      check("sb_nonempty", 98'(exp_q.size() != 0), 98'd1);
      if (exp_q.size() != 0) begin
        mon_exp     = exp_q.pop_front();
        mon_exp[96] = ds_is_branch;
        check("sb_bus", fs_to_ds_bus, mon_exp);
      end
    end
  end

  // Advance to the next cycle with one-shot inputs cleared.
  task automatic next();
    @(posedge clk);
    #1;
    pfs_to_fs_valid   = 1'b0;
    inst_sram_data_ok = 1'b0;
    ws_ex             = 1'b0;
    ws_eret           = 1'b0;
  endtask

  task automatic offer(input bit adef, input logic [31:0] pc);
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_bus   = {adef, pc};
  endtask

  task automatic resp(input logic [31:0] data);
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = data;
  endtask

  initial begin
    reset             = 1'b1;
    pfs_to_fs_valid   = 1'b0;
    pfs_to_fs_bus     = '0;
    ds_allowin        = 1'b1;
    ds_is_branch      = 1'b0;
    inst_sram_rdata   = '0;
    inst_sram_data_ok = 1'b0;
    ws_ex             = 1'b0;
    ws_eret           = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 98'(fs_to_ds_valid), 98'd0);
    check("rst_allowin", 98'(fs_allowin), 98'd1);
    check("rst_full", 98'(fs_buff_full), 98'd0);
    check("rst_waiting", 98'(inst_sram_data_waiting), 98'd0);
    check("rst_bus", fs_to_ds_bus, 98'd0);

    // In-order responses for three pcs.
    next(); offer(1'b0, 32'hBFC00000); exp_q.push_back(mk(1'b0, 32'hBFC00000, 32'h11));
    next(); offer(1'b0, 32'hBFC00004); exp_q.push_back(mk(1'b0, 32'hBFC00004, 32'h22));
    next(); offer(1'b0, 32'hBFC00008); exp_q.push_back(mk(1'b0, 32'hBFC00008, 32'h33));
    next();
    @(negedge clk); check("t1_waiting", 98'(inst_sram_data_waiting), 98'd1);
    next(); resp(32'h11);
    @(negedge clk); check("t1_valid_m0", 98'(fs_to_ds_valid), 98'(Byp));
    next(); resp(32'h22);
    @(negedge clk); check("t1_valid_m1", 98'(fs_to_ds_valid), 98'd1);
    next(); resp(32'h33);
    @(negedge clk); check("t1_valid_m2", 98'(fs_to_ds_valid), 98'd1);
    next();
    @(negedge clk); check("t1_valid_m3", 98'(fs_to_ds_valid), 98'(!Byp));
    next();
    @(negedge clk); check("t1_valid_idle", 98'(fs_to_ds_valid), 98'd0);

    // Full queue: no push until the cycle after a pop.
    ds_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next(); offer(1'b1, 32'hA0000000 + 32'(4 * i));
      exp_q.push_back(mk(1'b1, 32'hA0000000 + 32'(4 * i), 32'h0));
    end
    next(); offer(1'b1, 32'hA0000010);
    @(negedge clk);
    check("t2_allowin_full", 98'(fs_allowin), 98'd0);
    check("t2_buff_full", 98'(fs_buff_full), 98'd1);
    check("t2_valid_held", 98'(fs_to_ds_valid), 98'd1);
    next(); offer(1'b1, 32'hA0000010);
    @(negedge clk); check("t2_allowin_hold", 98'(fs_allowin), 98'd0);
    next(); offer(1'b1, 32'hA0000010); ds_allowin = 1'b1;
    @(negedge clk); check("t2_no_pushthru", 98'(fs_allowin), 98'd0);
    next(); offer(1'b1, 32'hA0000010); ds_allowin = 1'b0;
    exp_q.push_back(mk(1'b1, 32'hA0000010, 32'h0));
    @(negedge clk); check("t2_allowin_after_pop", 98'(fs_allowin), 98'd1);
    next();
    @(negedge clk); check("t2_full_again", 98'(fs_buff_full), 98'd1);
    ds_allowin = 1'b1;
    repeat (5) next();
    @(negedge clk); check("t2_drained", 98'(fs_to_ds_valid), 98'd0);

    // adef entry between two normal pcs; bd follows ds_is_branch.
    ds_is_branch = 1'b1;
    next(); offer(1'b0, 32'hBFC00010); exp_q.push_back(mk(1'b0, 32'hBFC00010, 32'hAA));
    next(); offer(1'b1, 32'hBFC00002); exp_q.push_back(mk(1'b1, 32'hBFC00002, 32'h0));
    next(); offer(1'b0, 32'hBFC00018); exp_q.push_back(mk(1'b0, 32'hBFC00018, 32'hBB));
    next();
    next(); resp(32'hAA);
    next(); resp(32'hBB);
    repeat (3) next();
    ds_is_branch = 1'b0;
    @(negedge clk); check("t3_waiting", 98'(inst_sram_data_waiting), 98'd0);

    // ws_ex with three pending: three responses are dropped.
    next(); offer(1'b0, 32'hBFC00100);
    next(); offer(1'b0, 32'hBFC00104);
    next(); offer(1'b0, 32'hBFC00108);
    next(); ws_ex = 1'b1;
    @(negedge clk); check("t4_valid_flush", 98'(fs_to_ds_valid), 98'd0);
    next();
    @(negedge clk);
    check("t4_valid_after", 98'(fs_to_ds_valid), 98'd0);
    check("t4_waiting_cancel", 98'(inst_sram_data_waiting), 98'd1);
    for (int k = 0; k < 3; k++) begin
      next(); resp(32'hDEAD0000 + 32'(k));
      @(negedge clk); check("t4_waiting_drop", 98'(inst_sram_data_waiting), 98'd1);
    end
    next();
    @(negedge clk); check("t4_waiting_fall", 98'(inst_sram_data_waiting), 98'd0);
    next(); offer(1'b0, 32'hBFC00380); exp_q.push_back(mk(1'b0, 32'hBFC00380, 32'hCAFE0380));
    next();
    next(); resp(32'hCAFE0380);
    next();
    next();

    // ws_eret together with data_ok, two pending: one response still owed.
    next(); offer(1'b0, 32'hBFC00200);
    next(); offer(1'b0, 32'hBFC00204);
    next();
    next(); ws_eret = 1'b1; resp(32'h77777777);
    @(negedge clk); check("t5_valid_flush", 98'(fs_to_ds_valid), 98'd0);
    next(); offer(1'b0, 32'hBFC00384); exp_q.push_back(mk(1'b0, 32'hBFC00384, 32'h5A5A5A5A));
    @(negedge clk); check("t5_valid_after", 98'(fs_to_ds_valid), 98'd0);
    next(); resp(32'h66666666);
    @(negedge clk); check("t5_valid_drop", 98'(fs_to_ds_valid), 98'd0);
    next(); resp(32'h5A5A5A5A);
    @(negedge clk); check("t5_valid_resp", 98'(fs_to_ds_valid), 98'(Byp));
    next();
    next();
    @(negedge clk); check("t5_waiting_end", 98'(inst_sram_data_waiting), 98'd0);

    // Reset with entries queued and responses cancelled.
    next(); offer(1'b0, 32'hBFC00300);
    next(); offer(1'b0, 32'hBFC00304);
    next(); ws_ex = 1'b1;
    next(); offer(1'b1, 32'hBFC00306); ds_allowin = 1'b0;
    next(); offer(1'b1, 32'hBFC0030A);
    next();
    @(negedge clk);
    check("t6_allowin_bound", 98'(fs_allowin), 98'd0);
    check("t6_valid_pre", 98'(fs_to_ds_valid), 98'd1);
    check("t6_waiting_pre", 98'(inst_sram_data_waiting), 98'd1);
    next(); reset = 1'b1;
    next(); reset = 1'b0;
    @(negedge clk);
    check("t6_valid_rst", 98'(fs_to_ds_valid), 98'd0);
    check("t6_allowin_rst", 98'(fs_allowin), 98'd1);
    check("t6_waiting_rst", 98'(inst_sram_data_waiting), 98'd0);
    check("t6_full_rst", 98'(fs_buff_full), 98'd0);
    check("t6_bus_rst", fs_to_ds_bus, 98'd0);

    check("sb_drained", 98'(exp_q.size()), 98'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
